// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: symbolic op codes, machine opcodes and the
// encoder FSM state type. The 11-bit opcodes match the main decoder's table.
package legv8_pkg;

  // Symbolic operation selector carried on the descriptor stream.
  typedef enum logic [2:0] {
    OP_LDUR    = 3'd0,
    OP_STUR    = 3'd1,
    OP_CBZ     = 3'd2,
    OP_ADD     = 3'd3,
    OP_SUB     = 3'd4,
    OP_AND     = 3'd5,
    OP_ORR     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_t;

  // 11-bit primary opcodes for the R and D formats.
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;

  // 8-bit opcode for the CB format (CBZ).
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  // Encoder write-side state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no write pending
    ST_EMIT = 2'd1,  // a registered word is being written this cycle
    ST_FULL = 2'd2   // every imem word written, nothing pending
  } state_t;

  // True when a 19-bit two's-complement value survives truncation to
  // 9 bits, i.e. the bits above the 9-bit sign bit all copy it.
  function automatic logic fits_simm9(input logic [18:0] imm);
    return (&imm[18:8]) || !(|imm[18:8]);
  endfunction

endpackage

// File: rtl/legv8_encode.sv
// Combinational LEGv8 encoder: one symbolic descriptor in, one 32-bit
// machine word plus a legality flag out. No state lives here.
module legv8_encode
  import legv8_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Select the field layout by instruction format and flag unencodable input.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    word  = '0;
    legal = 1'b0;
    case (op_t'(op))
      // R format: opcode | Rm | shamt=0 | Rn | Rd
      OP_ADD: begin
        word  = {OPC_ADD, rm, 6'b000000, rn, rd};
        legal = 1'b1;
      end
      OP_SUB: begin
        word  = {OPC_SUB, rm, 6'b000000, rn, rd};
        legal = 1'b1;
      end
      OP_AND: begin
        word  = {OPC_AND, rm, 6'b000000, rn, rd};
        legal = 1'b1;
      end
      OP_ORR: begin
        word  = {OPC_ORR, rm, 6'b000000, rn, rd};
        legal = 1'b1;
      end
      // D format: opcode | DT_address[8:0] | op2=00 | Rn | Rt
      // The offset must fit the signed 9-bit field or the word is rejected.
      OP_LDUR: begin
        word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        legal = fits_simm9(imm);
      end
      OP_STUR: begin
        word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        legal = fits_simm9(imm);
      end
      // CB format: opcode | 19-bit word offset | Rt. Always representable.
      OP_CBZ: begin
        word  = {OPC_CBZ, imm, rd};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Streaming LEGv8 instruction encoder. Accepts descriptors over valid/ready,
// encodes them and writes the words to consecutive imem addresses starting
// at 0, one registered stage behind the handshake. Stops accepting once
// every imem word is written; clear or reset restarts from address 0.
module legv8_instr_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,     // asynchronous, active low
  input  logic              clear,     // synchronous restart
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  // count value meaning "imem completely written" and the increment step,
  // both sized to the counter so no width adaptation is needed.
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        legal_accept;
  logic        illegal_accept;
  logic        is_full;
  state_t      state;
  state_t      state_next;

  legv8_encode u_encode (
    .op    (in_op),
    .rd    (in_rd),
    .rn    (in_rn),
    .rm    (in_rm),
    .imm   (in_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  // Handshake: clear takes priority over any descriptor offered in the
  // same cycle, and nothing is taken once imem is full.
  assign is_full        = (count == DEPTH_CNT);
  assign in_ready       = reset && !clear && !is_full;
  assign accept         = in_valid && in_ready;
  assign legal_accept   = accept && enc_legal;
  assign illegal_accept = accept && !enc_legal;

  // The write strobe is the EMIT state itself, so it is a clean register
  // output and drops immediately when reset asserts.
  assign wr_en = (state == ST_EMIT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a legal accept always schedules a write; otherwise
  // settle into FULL once the last word has gone out, else IDLE.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_EMIT: begin
          if (legal_accept) begin
            state_next = ST_EMIT;
          end else if (is_full) begin
            state_next = ST_FULL;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_FULL: begin
          state_next = ST_FULL;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Output stage, word counter and sticky error. Address and data only
  // update on a legal accept, so they hold their last value otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_addr <= '0;
      wr_data <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else if (clear) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (legal_accept) begin
        wr_addr <= count[ADDR_W-1:0];
        wr_data <= enc_word;
        count   <= count + CNT_ONE;
      end
      if (illegal_accept) begin
        err <= 1'b1;
      end
    end
  end

endmodule
